// File: rtl/cpu_intr_pkg.sv
// cpu_intr_pkg
// Shared definitions for the interrupt/timer controller: register word
// offsets, the "no interrupt" id, and a helper that widens an id to a bus word.
package cpu_intr_pkg;

  localparam logic [2:0] PRESCALE_OFF = 3'd0;
  localparam logic [2:0] TCTRL_OFF    = 3'd1;
  localparam logic [2:0] ENABLE_OFF   = 3'd2;
  localparam logic [2:0] TRIGGER_OFF  = 3'd3;
  localparam logic [2:0] PENDING_OFF  = 3'd4;
  localparam logic [2:0] CLAIM_OFF    = 3'd5;
  localparam logic [2:0] COMPLETE_OFF = 3'd6;

  localparam int         ID_W   = 5;
  localparam logic [4:0] NO_IRQ = 5'd0;

  function automatic logic [31:0] id_to_word(input logic [ID_W-1:0] id);
    return {{(32-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/cpu_intr_sync.sv
// cpu_intr_sync
// Per-line 2-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk_i    core clock
//   rst_n_i  asynchronous active-low reset
//   irq_i    raw asynchronous interrupt lines
//   level_o  synchronised level
//   rise_o   one-cycle pulse on a synchronised 0->1 transition
module cpu_intr_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] irq_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= irq_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/cpu_intr_ctrl.sv
// cpu_intr_ctrl
// Programmable timer tick plus external interrupt latch with a
// claim/complete register interface, feeding the CSR file.
// Ports:
//   clk, rst_n      core clock, asynchronous active-low reset
//   irq_in          raw interrupt lines, bit i is id i+1
//   addr, rd, wr    register word offset and one-cycle access strobes
//   data_in         write data
//   data_out        registered read data, valid the cycle after rd
//   timer_tick      one-cycle pulse every PRESCALE+1 cycles while enabled
//   ext_intr_tick   one-cycle pulse when the claimable set leaves zero
module cpu_intr_ctrl
  import cpu_intr_pkg::*;
#(
  parameter int          IRQ_COUNT      = 8,
  parameter logic [31:0] PRESCALE_RESET = 32'd999
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IRQ_COUNT-1:0] irq_in,
  input  logic [2:0]           addr,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 timer_tick,
  output logic                 ext_intr_tick
);

  logic [31:0]          prescale_q;
  logic [31:0]          cnt_q;
  logic                 ten_q;
  logic [IRQ_COUNT-1:0] en_q;
  logic [IRQ_COUNT-1:0] trig_q;
  logic [IRQ_COUNT-1:0] pend_q, pend_d;
  logic [IRQ_COUNT-1:0] isr_q, isr_d;
  logic                 any_q;
  logic [31:0]          data_out_q;
  logic                 timer_tick_q;
  logic                 ext_tick_q;

  logic [IRQ_COUNT-1:0] sync_level;
  logic [IRQ_COUNT-1:0] sync_rise;
  logic [IRQ_COUNT-1:0] claimable;
  logic [IRQ_COUNT-1:0] claim_mask;
  logic [IRQ_COUNT-1:0] cmp_mask;
  logic [ID_W-1:0]      claim_id;
  logic [31:0]          rdata;
  logic                 rd_en;
  logic                 claim_rd;
  logic                 cmp_wr;

  cpu_intr_sync #(.WIDTH(IRQ_COUNT)) u_sync (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .irq_i   (irq_in),
    .level_o (sync_level),
    .rise_o  (sync_rise)
  );

  // A write in the same cycle suppresses the read entirely, including claim.
  assign rd_en    = rd & ~wr;
  assign claim_rd = rd_en && (addr == CLAIM_OFF);
  assign cmp_wr   = wr && (addr == COMPLETE_OFF);

  assign claimable = pend_q & en_q & ~isr_q;

  // Highest index wins: later iterations overwrite lower ones.
  always_comb begin
    claim_id = NO_IRQ;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (claimable[i]) claim_id = ID_W'(i + 1);
    end
  end

  // Out-of-range or idle ids match no line, so they fall out naturally.
  always_comb begin
    claim_mask = '0;
    cmp_mask   = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      claim_mask[i] = claim_rd && (claim_id == ID_W'(i + 1));
      cmp_mask[i]   = cmp_wr && (data_in[ID_W-1:0] == ID_W'(i + 1)) && isr_q[i];
    end
  end

  assign isr_d = (isr_q | claim_mask) & ~cmp_mask;

  // Edge lines: a rise in the claim cycle keeps pending set so it is not lost.
  // Level lines use next-state in_service so a complete with the level still
  // high reasserts pending on the very next cycle.
  always_comb begin
    pend_d = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      if (trig_q[i]) pend_d[i] = (pend_q[i] & ~claim_mask[i]) | sync_rise[i];
      else           pend_d[i] = sync_level[i] & ~isr_d[i];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      PRESCALE_OFF: rdata = prescale_q;
      TCTRL_OFF:    rdata = {31'd0, ten_q};
      ENABLE_OFF:   rdata = {{(32-IRQ_COUNT){1'b0}}, en_q};
      TRIGGER_OFF:  rdata = {{(32-IRQ_COUNT){1'b0}}, trig_q};
      PENDING_OFF:  rdata = {{(32-IRQ_COUNT){1'b0}}, pend_q};
      CLAIM_OFF:    rdata = id_to_word(claim_id);
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ten_q      <= 1'b0;
      en_q       <= '0;
      trig_q     <= '0;
      pend_q     <= '0;
      isr_q      <= '0;
      any_q      <= 1'b0;
      ext_tick_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      if (wr && addr == TCTRL_OFF)   ten_q  <= data_in[0];
      if (wr && addr == ENABLE_OFF)  en_q   <= data_in[IRQ_COUNT-1:0];
      if (wr && addr == TRIGGER_OFF) trig_q <= data_in[IRQ_COUNT-1:0];
      if (rd_en) data_out_q <= rdata;
      pend_q     <= pend_d;
      isr_q      <= isr_d;
      any_q      <= |claimable;
      ext_tick_q <= (|claimable) & ~any_q;
    end
  end

  // A PRESCALE write takes priority over a terminal count in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q   <= PRESCALE_RESET;
      cnt_q        <= PRESCALE_RESET;
      timer_tick_q <= 1'b0;
    end else if (wr && addr == PRESCALE_OFF) begin
      prescale_q   <= data_in;
      cnt_q        <= data_in;
      timer_tick_q <= 1'b0;
    end else if (ten_q) begin
      if (cnt_q == 32'd0) begin
        cnt_q        <= prescale_q;
        timer_tick_q <= 1'b1;
      end else begin
        cnt_q        <= cnt_q - 32'd1;
        timer_tick_q <= 1'b0;
      end
    end else begin
      timer_tick_q <= 1'b0;
    end
  end

  assign data_out      = data_out_q;
  assign timer_tick    = timer_tick_q;
  assign ext_intr_tick = ext_tick_q;

endmodule

// File: doc/cpu_intr_ctrl.md
# cpu_intr_ctrl

Interrupt and timer source that sits directly upstream of the CPU CSR file and drives its `timer_tick` and `ext_intr_tick` inputs. It divides the core clock into a programmable timer tick. It synchronises and latches up to `IRQ_COUNT` external interrupt lines with per-line edge or level triggering. It exposes a memory-mapped claim/complete interface so the supervisor trap handler can identify and retire the interrupting source.

## Interface
- `IRQ_COUNT`, 8: number of external interrupt lines, 1..31; line ids are 1..`IRQ_COUNT`, and id 0 means "none".
- `PRESCALE_RESET`, 32'd999: reset value of the timer reload register.
- `clk`  in  1  core clock; the single clock of the block.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `irq_in`  in  `IRQ_COUNT`  raw external interrupt lines, asynchronous to `clk`; bit i is id i+1.
- `addr`  in  3  word offset of the register being accessed.
- `rd`  in  1  read strobe, one cycle per access.
- `wr`  in  1  write strobe, one cycle per access.
- `data_in`  in  32  write data.
- `data_out`  out  32  registered read data.
- `timer_tick`  out  1  one-cycle pulse per prescaler period, to CSR `timer_tick`.
- `ext_intr_tick`  out  1  one-cycle pulse on a new claimable interrupt, to CSR `ext_intr_tick`.

## Operation
- Register map by `addr`:
  - 0 PRESCALE: R/W, 32 bits.
  - 1 TCTRL: R/W; bit0 is timer enable.
  - 2 ENABLE: R/W, `IRQ_COUNT` bits, bit i gates id i+1.
  - 3 TRIGGER: R/W; a bit set means edge-triggered, clear means level-triggered.
  - 4 PENDING: RO; writes are ignored.
  - 5 CLAIM: a read returns the claimed id.
  - 6 COMPLETE: a write of an id retires it.
  - 7 reserved: reads return 0.
- Unused upper bits of every register read as 0.
- Synchronisation: `irq_in` passes through a 2-flop synchroniser. The edge detector compares the synchronised value with its previous sample; only rising edges count.
- Pending, edge lines: the bit sets on a synchronised rising edge and clears on claim.
- Pending, level lines: the bit equals the synchronised level AND NOT in_service.
- Claimable set = PENDING & ENABLE & ~in_service.
- Claim read:
  - Returns the highest-numbered claimable id, or 0 if none.
  - Clears that line's pending bit and sets its in_service bit.
  - A claim returning 0 has no side effect.
- Complete write: clears in_service for `data_in[4:0]`. An id of 0, greater than `IRQ_COUNT`, or not in service is ignored.
- `ext_intr_tick`: registered pulse asserted the cycle after the claimable set goes from zero to nonzero. A further line joining an already nonzero set produces no pulse; the CSR's sip bit is sticky.
- Timer:
  - Down-counter reloaded from PRESCALE.
  - While TCTRL.0=1 it decrements each cycle. At 0 it pulses `timer_tick` and reloads, giving a period of PRESCALE+1 cycles; PRESCALE=0 ticks every cycle.
  - While TCTRL.0=0 the counter holds its value.
  - Any write to PRESCALE also loads the counter with the new value.

## Timing
- Reset values:
  - Outputs: `data_out`, `timer_tick`, `ext_intr_tick` are 0.
  - Registers: PRESCALE=`PRESCALE_RESET`, counter=`PRESCALE_RESET`, TCTRL=0, ENABLE=0, TRIGGER=0 (all level), PENDING=0, in_service=0.
  - Synchroniser and edge-history flops are 0.
- Reset mid-operation discards all claims and pending state immediately.
- Reads: `data_out` is valid the cycle after `rd` and holds until the next `rd`. Side effects (claim) commit on the `rd` cycle.
- `rd` and `wr` together in one cycle: the write is performed and the read is ignored.
- Latency from an `irq_in` rise to PENDING is 3 cycles: 2 synchroniser flops plus the latch. `ext_intr_tick` follows 1 cycle later.
- Edge arrival on a line in the same cycle it is claimed: pending stays set, so the new edge is not lost.
- Complete and a level still asserted: pending reasserts on the next cycle.
- Write to ENABLE that creates a claimable line: `ext_intr_tick` pulses per the zero-to-nonzero rule.
- The counter is 32 bits wide; a reload is never skipped.

## Structure
- Shared package `cpu_intr_pkg`:
  - Register offset constants: PRESCALE_OFF, TCTRL_OFF, ENABLE_OFF, TRIGGER_OFF, PENDING_OFF, CLAIM_OFF, COMPLETE_OFF.
  - The "no interrupt" id 0.
- One sub-module `cpu_intr_sync`: a per-line 2-flop synchroniser plus rising-edge detector, instantiated `IRQ_COUNT` wide.
- The priority encoder is a combinational loop inside the top module, highest index wins, matching the CSR file's convention.

## Test plan
- Timer period: reset, write PRESCALE=3, TCTRL=1 → `timer_tick` pulses every 4 cycles. Write TCTRL=0 → no further pulses.
- Edge line:
  - Setup: TRIGGER=0x01, ENABLE=0x01; pulse `irq_in[0]` for 1 cycle.
  - PENDING=0x01 after 3 cycles; `ext_intr_tick` pulses once.
  - CLAIM reads 1 and PENDING becomes 0.
  - A second edge before COMPLETE sets pending but no tick (in service); after COMPLETE=1, the tick fires.
- Priority: level lines 2 and 5 held high, ENABLE=0xFF → CLAIM reads 5, then 2, then 0.
- Level reassert: level line 3 held high → claim 3, complete 3 → PENDING bit 2 set again the next cycle; a new tick.
- Bad completes: COMPLETE=0, COMPLETE=9, and COMPLETE of an id not in service → no state change.
- Async reset: assert `rst_n` low mid-claim with the timer running → all outputs 0 and the counter reloads to `PRESCALE_RESET` immediately.
